// File: rtl/cba_wide_add_seq_pkg.sv
// Shared constants and state encoding for the slice-serial wide adder.
package cba_wide_add_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cba_wide_add_seq_adder.sv
// 8-bit carry-bypass adder: two 4-bit ripple blocks, each skipped when all its bits propagate.
module CarryBypassAdder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] prop;
  logic [2:0] blk_c;
  logic       rc;

  assign prop = a ^ b;

  // NOTE: rc is a chained temporary, so it must use blocking assignments and get a default first.
  always_comb begin
    sum      = '0;
    blk_c    = '0;
    rc       = 1'b0;
    blk_c[0] = cin;
    for (int blk = 0; blk < 2; blk++) begin
      rc = blk_c[blk];
      for (int i = 0; i < 4; i++) begin
        sum[blk*4+i] = prop[blk*4+i] ^ rc;
        rc           = (a[blk*4+i] & b[blk*4+i]) | (rc & prop[blk*4+i]);
      end
      // A fully propagating block forwards its incoming carry directly.
      blk_c[blk+1] = (&prop[blk*4 +: 4]) ? blk_c[blk] : rc;
    end
  end

  assign cout = blk_c[2];

endmodule

// File: rtl/cba_wide_add_seq.sv
// Wide unsigned adder that reuses one 8-bit carry-bypass adder, one slice per clock, LSB first.
module cba_wide_add_seq
  import cba_wide_add_seq_pkg::*;
#(
  parameter  int N_SLICES = 4,
  localparam int W        = SLICE_W * N_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;

  logic [SLICE_W-1:0] add_a, add_b, add_sum;
  logic               add_cout;

  assign add_a = a_q[SLICE_W*idx_q +: SLICE_W];
  assign add_b = b_q[SLICE_W*idx_q +: SLICE_W];

  CarryBypassAdder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d      = add_cout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cba_wide_add_seq.sv
// Scoreboard bench for cba_wide_add_seq: directed cases plus randomized traffic against a + b + cin.
module tb_cba_wide_add_seq;

  localparam int N = 4;
  localparam int W = 8 * N;

  typedef struct {
    logic [W:0] exp;
    int         acc;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;
  txn_t sb[$];

  cba_wide_add_seq #(.N_SLICES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic cv);
    return {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands until accepted; returns (at #1 after the accept edge) the accept cycle.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input bit keep, output int acc);
    int waited = 0;
    acc   = -1;
    a_i   = av;
    b_i   = bv;
    cin_i = cv;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      step();
      waited++;
    end
    if (!in_ready) begin
      fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    sb.push_back('{exp: model(av, bv, cv), acc: acc});
    step();
    if (!keep) begin
      in_valid = 1'b0;
      a_i = rand_w();
      b_i = rand_w();
      cin_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_drain();
    int waited = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && waited < 100) begin
      step();
      waited++;
    end
    if (sb.size() != 0) begin
      fail("drain_timeout");
      sb.delete();
    end
  endtask

  // Monitor: checks result latency on out_valid rising and pops/compares at each output handshake.
  initial begin
    logic prev_ov = 1'b0;
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) fail("unexpected_out_valid");
          else check("latency", 64'(cyc - sb[0].acc), 64'(N));
        end
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          check("sum", 64'(sum), 64'(e.exp[W-1:0]));
          check("cout", 64'(cout), 64'(e.exp[W]));
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, prev_acc, waited;
    logic [W:0] e;

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    check("rst_sum", 64'(sum), 0);
    check("rst_cout", 64'(cout), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_busy", 64'(busy), 0);

    // Directed arithmetic cases
    out_ready = 1'b1;
    send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, acc);
    check("busy_in_run", 64'(busy), 1);
    check("in_ready_in_run", 64'(in_ready), 0);
    wait_drain();
    check("direct_expect_1", 64'(model(32'h000000FF, 32'h00000001, 1'b0)), 64'h100);
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, acc);
    wait_drain();
    send(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, acc);
    wait_drain();
    send(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, acc);
    wait_drain();

    // Back-pressure in DONE with ignored input traffic
    out_ready = 1'b0;
    e = model(32'hDEADBEEF, 32'h01234567, 1'b1);
    send(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, acc);
    waited = 0;
    while (!out_valid && waited < 20) begin step(); waited++; end
    if (!out_valid) fail("done_timeout");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a_i = rand_w();
      b_i = rand_w();
      check("bp_sum", 64'(sum), 64'(e[W-1:0]));
      check("bp_cout", 64'(cout), 64'(e[W]));
      check("bp_out_valid", 64'(out_valid), 1);
      check("bp_in_ready", 64'(in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", 64'(in_ready), 1);
    check("bp_release_out_valid", 64'(out_valid), 0);

    // Reset on the second RUN cycle aborts the operation
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0, acc);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    check("abort_sum", 64'(sum), 0);
    check("abort_cout", 64'(cout), 0);
    check("abort_out_valid", 64'(out_valid), 0);
    check("abort_in_ready", 64'(in_ready), 1);
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0, acc);
    wait_drain();

    // Back-to-back with in_valid held high and out_ready=1
    out_ready = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 4; i++) begin
      send(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'b1, acc);
      if (prev_acc >= 0 && acc >= 0) check("issue_interval", 64'(acc - prev_acc), 64'(N + 2));
      prev_acc = acc;
    end
    in_valid = 1'b0;
    wait_drain();

    // Randomized traffic with random consumer stalls and corner operands
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] av, bv;
      av = rand_w();
      case ($urandom_range(0, 3))
        0: bv = ~av;
        1: bv = '0;
        default: bv = rand_w();
      endcase
      send(av, bv, 1'($urandom_range(0, 1)), 1'b0, acc);
      repeat ($urandom_range(0, 8)) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    rand_rdy = 1'b0;
    wait_drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cba_wide_add_seq.md
Name: cba_wide_add_seq

Overview:
- Multi-cycle sequencer that adds wide operands (8*N_SLICES bits) by time-multiplexing one instance of the existing 8-bit CarryBypassAdder datapath.
- Processes one 8-bit slice per clock, LSB slice first, registering the carry between slices.
- Uses valid/ready handshakes on both input and output, so it sits between an operand producer and a result consumer in the arithmetic subsystem.

Parameters:
- N_SLICES, 4, number of 8-bit slices; operand width W = 8*N_SLICES; legal range 2..16.

Ports:
- clk  input  1  system clock; rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand set present on a/b/cin
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry into slice 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  W  registered result
- cout  output  1  carry out of the top slice
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset is synchronous and active-high on clk; the clock port is clk and the reset port is rst. On rst=1 at a clock edge:
  - state=IDLE, sum=0, cout=0, out_valid=0, slice index=0, carry register=0, operand registers=0.
  - in_ready is 1 from the first edge after rst deasserts.
- States:
  - IDLE: in_ready=1, busy=0.
    - If in_valid=1, latch a, b and cin into the carry register, set idx=0, and go to RUN.
  - RUN: in_ready=0, busy=1.
    - Drive adder a=A_reg[8*idx+:8], b=B_reg[8*idx+:8], cin=carry.
    - At the edge, write sum[8*idx+:8] with the adder sum and set carry to the adder cout.
    - If idx==N_SLICES-1, set cout to the adder cout, set out_valid=1 and go to DONE. Otherwise idx++.
  - DONE: out_valid=1, in_ready=0, busy=1.
    - sum and cout hold stable while out_ready=0.
    - When out_ready=1 at an edge, out_valid goes to 0 and the state goes to IDLE.
- Latency and throughput:
  - The accept edge is T. out_valid is high from edge T+N_SLICES.
  - Minimum issue interval is N_SLICES+2 cycles: accept, N_SLICES RUN cycles, at least one DONE cycle.
  - There is no accept in the same cycle as out_ready, which keeps the handshake simple.
- Arithmetic:
  - {cout,sum} = a + b + cin, unsigned, modulo 2^(W+1). No signed overflow flag.
- sum register behaviour:
  - Slices not yet written in RUN keep their previous values; sum is only meaningful while out_valid=1.
  - The sum register is not cleared on a new accept.
- Boundary conditions:
  - in_valid while RUN or DONE: ignored (in_ready=0). The producer must hold operands until accepted.
  - Changes on the a/b inputs after accept do not affect the result, because operands are registered.
  - out_ready=1 while not in DONE: no effect.
  - rst during RUN or DONE: the operation is aborted, all outputs go to their reset values and no result is emitted.
  - All-propagate operands (a^b all ones) must produce the correct carry chain across slice boundaries; the registered carry is the only inter-slice path.
  - The index counter never exceeds N_SLICES-1. Width is $clog2(N_SLICES), minimum 1.
- The 8-bit adder is purely combinational; the only critical path is operand mux → adder → sum/carry registers.

Decomposition:
- Shared package:
  - slice width constant SLICE_W=8.
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module: instantiate the existing CarryBypassAdder (ports a, b, cin, sum, cout) once.
- No other sub-modules are needed.

Test Plan:
1. Basic add, N_SLICES=4: a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0. out_valid rises exactly 4 edges after accept.
2. Full carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1.
3. All-propagate pattern: a=0xAAAAAAAA, b=0x55555555, cin=0 → sum=0xFFFFFFFF, cout=0. Then repeat with cin=1 → sum=0x00000000, cout=1.
4. Back-pressure and ignored input:
   - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b → sum, cout and out_valid stay stable, and in_ready=0 throughout.
   - After out_ready=1 for one edge → IDLE and in_ready=1.
5. Reset mid-operation: accept a=0x12345678, b=0x11111111, then assert rst on the 2nd RUN cycle → next edge gives sum=0, cout=0, out_valid=0, in_ready=1. A following transaction, 0x12345678+0x11111111 → 0x23456789, completes correctly.
6. Back-to-back transactions with in_valid held high and out_ready=1 → results in order, issue interval = 6 cycles, and no operand from transaction 2 is sampled before transaction 1 is accepted out.
